dac_update_arbiter: RTL
=======================

Name: dac_update_arbiter

Overview:
- Schedules 10-bit code updates into the on-chip DAC from two requesters:
  - requester 0: RISC-V core output stream
  - requester 1: test/waveform source
- Runs on the PLL-generated CLK.
- Paces updates with a programmable sample-rate tick.
- Arbitrates round-robin and slew-limits each DAC step; the DAC D input sees only rate-controlled, bounded transitions.

Parameters:
- DAC_W, 10, DAC code width.
- DIV_W, 16, width of div_ratio.
- SLEW_MAX, 0, max code change per tick; 0 = unlimited.
- RESET_CODE, 512, dac_code and target value after reset (midscale).

Ports:
- CLK  in  1  system clock from PLL.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = ticks run; 0 = counter held at 0, no DAC updates.
- div_ratio  in  DIV_W  tick period in CLK cycles; 0 and 1 both mean every cycle.
- req0_valid  in  1  requester 0 offers a sample.
- req0_data  in  DAC_W  requester 0 sample.
- req0_ready  out  1  requester 0 holding slot empty.
- req1_valid  in  1  requester 1 offers a sample.
- req1_data  in  DAC_W  requester 1 sample.
- req1_ready  out  1  requester 1 holding slot empty.
- underrun_clr  in  1  clears the underrun flag.
- dac_code  out  DAC_W  registered code to DAC D.
- dac_update  out  1  one-cycle pulse coincident with each new dac_code.
- grant_id  out  1  requester whose sample last loaded target.
- underrun  out  1  sticky underrun flag.

Behaviour:
- All state updates on rising CLK edge; reset is synchronous and active-high.
- Reset values:
  - dac_code = target = RESET_CODE
  - both slots empty, so req*_ready = 1
  - divider count = 0, dac_update = 0, grant_id = 0, underrun = 0
  - last_grant = 1, so req0 wins the first contention
- Reset mid-operation discards held samples and any in-progress slew.
- Holding slots: one entry per requester.
  - req_i_ready = ~full_i, registered.
  - A transfer happens when valid & ready in the same cycle, which sets full_i next edge.
  - A drained slot shows ready = 1 on the cycle after the drain.
  - Slots accept samples even when enable = 0.
- Divider:
  - While enable = 1, count increments each cycle.
  - tick = (count >= div_ratio-1), saturated for div_ratio ≤ 1; on tick, count wraps to 0.
  - Lowering div_ratio mid-count fires a tick immediately via the >= compare.
  - enable = 0 forces count to 0 and tick to 0.
- On a tick:
  - Drain eligibility: dac_code == target, i.e. the previous slew has finished.
  - If eligible and any slot is full, the grant goes to the full slot. If both are full, it goes to ~last_grant.
  - The granted slot clears. target takes the slot's data. grant_id and last_grant take the winner's index.
  - next_target = new data if granted, else the held target.
  - With d = next_target − dac_code (signed, DAC_W+1 bits): dac_code += clamp(d, −SLEW_MAX, +SLEW_MAX). SLEW_MAX = 0 means dac_code = next_target.
  - Arithmetic never wraps: dac_code stays between its old value and next_target.
- dac_update = 1 on the cycle after every tick (including ticks with no code change); 0 otherwise.
- underrun:
  - Set on a tick that is eligible while both slots are empty.
  - underrun_clr clears it. If clear and set occur in the same cycle, set wins.
- Without a tick, dac_code, target and grant state hold.
- A slot filling on the same edge as a tick is not seen by that tick's arbitration; it is eligible from the next tick.

Decomposition:
- Package dac_ctrl_pkg:
  - DAC_W
  - RESET_CODE
  - requester index constants REQ_CORE = 0, REQ_TEST = 1
- Sub-module dac_rate_divider: count register, tick generation, enable and div_ratio handling.
- Arbiter, slots and slew logic stay in the top module.

Test Plan:
- Reset: after reset, dac_code = 512, req0_ready = req1_ready = 1, dac_update = 0, underrun = 0.
- Pacing: div_ratio = 4, enable = 1, req0 sends 100 then 200 back-to-back, SLEW_MAX = 0.
  - dac_update pulses every 4 cycles.
  - dac_code = 100 at the first pulse, 200 at the next.
  - req0_ready drops for one cycle after each accept until that slot drains.
- Round-robin: both slots full every tick (req0 = 10, req1 = 20), div_ratio = 1, SLEW_MAX = 0.
  - dac_code sequence 10, 20, 10, 20.
  - grant_id alternates 0, 1, 0, 1.
- Slew: SLEW_MAX = 64, dac_code = 512, req1 = 1000, div_ratio = 1.
  - dac_code sequence 576, 640, … 960, 1000.
  - A req0 sample waiting during the slew is not granted until the tick after dac_code reaches 1000.
- Underrun and enable:
  - No requests, enable = 1 → underrun = 1 after the first tick.
  - underrun_clr on an underrun tick leaves underrun = 1.
  - enable = 0 → no dac_update pulses; samples still accepted.
- Reset mid-slew: assert reset during the 512→1000 slew → next cycle dac_code = 512, both ready = 1, no further dac_update until a new tick.

Source files
------------

// File: rtl/dac_ctrl_pkg.sv
// Shared constants and types for the DAC update path.
package dac_ctrl_pkg;

   localparam int unsigned DAC_W      = 10;
   localparam int unsigned DIV_W      = 16;
   localparam int unsigned RESET_CODE = 512;

   typedef enum logic {
      REQ_CORE = 1'b0,
      REQ_TEST = 1'b1
   } req_id_e;

endpackage : dac_ctrl_pkg

// File: rtl/dac_rate_divider.sv
// Sample-rate divider: produces a tick every div_ratio cycles while enabled.
module dac_rate_divider #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             enable_i,
   input  logic [DIV_W-1:0] div_ratio_i,
   output logic             tick_c
);

   logic [DIV_W-1:0] count_q;
   logic [DIV_W-1:0] count_d;
   logic [DIV_W-1:0] limit;

   // A >= compare lets a lowered ratio fire at once instead of waiting for wrap.
   always_comb begin
      limit   = (div_ratio_i == '0) ? '0 : div_ratio_i - DIV_W'(1);
      tick_c  = enable_i && (count_q >= limit);
      count_d = count_q + DIV_W'(1);
      if (!enable_i || tick_c) begin
         count_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : dac_rate_divider

// File: rtl/dac_update_arbiter.sv
// Round-robin, rate-paced, slew-limited scheduler of DAC code updates from two requesters.
module dac_update_arbiter #(
   parameter int unsigned DAC_W      = dac_ctrl_pkg::DAC_W,
   parameter int unsigned DIV_W      = dac_ctrl_pkg::DIV_W,
   parameter int unsigned SLEW_MAX   = 0,
   parameter int unsigned RESET_CODE = dac_ctrl_pkg::RESET_CODE
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             enable,
   input  logic [DIV_W-1:0] div_ratio,
   input  logic             req0_valid,
   input  logic [DAC_W-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [DAC_W-1:0] req1_data,
   output logic             req1_ready,
   input  logic             underrun_clr,
   output logic [DAC_W-1:0] dac_code,
   output logic             dac_update,
   output logic             grant_id,
   output logic             underrun
);

   import dac_ctrl_pkg::*;

   localparam logic [DAC_W-1:0]        RST_CODE = DAC_W'(RESET_CODE);
   localparam logic [DAC_W-1:0]        SLEW_U   = DAC_W'(SLEW_MAX);
   localparam logic signed [DAC_W:0]   SLEW_S   = $signed((DAC_W+1)'(SLEW_MAX));

   logic                    tick;

   logic [1:0]              ready_q,   ready_d;
   logic [DAC_W-1:0]        data0_q,   data0_d;
   logic [DAC_W-1:0]        data1_q,   data1_d;
   logic [DAC_W-1:0]        code_q,    code_d;
   logic [DAC_W-1:0]        target_q,  target_d;
   req_id_e                 last_q,    last_d;
   req_id_e                 gid_q,     gid_d;
   logic                    upd_q,     upd_d;
   logic                    und_q,     und_d;

   logic [1:0]              full;
   logic                    eligible;
   logic                    grant_vld;
   req_id_e                 winner;
   logic [DAC_W-1:0]        next_target;
   logic signed [DAC_W:0]   diff;
   logic [DAC_W-1:0]        code_step;

   dac_rate_divider #(
      .DIV_W (DIV_W)
   ) u_divider (
      .CLK         (CLK),
      .reset       (reset),
      .enable_i    (enable),
      .div_ratio_i (div_ratio),
      .tick_c      (tick)
   );

   // Arbitration, slot bookkeeping and slew stepping for the current cycle.
   always_comb begin
      ready_d     = ready_q;
      data0_d     = data0_q;
      data1_d     = data1_q;
      target_d    = target_q;
      last_d      = last_q;
      gid_d       = gid_q;
      und_d       = und_q;
      code_d      = code_q;
      upd_d       = tick;

      full        = ~ready_q;
      eligible    = tick && (code_q == target_q);
      grant_vld   = eligible && (full != 2'b00);

      if (full == 2'b11) begin
         winner = (last_q == REQ_CORE) ? REQ_TEST : REQ_CORE;
      end else begin
         winner = full[1] ? REQ_TEST : REQ_CORE;
      end

      next_target = target_q;
      if (grant_vld) begin
         next_target = (winner == REQ_TEST) ? data1_q : data0_q;
      end

      // Diff is one bit wider so the step never wraps past next_target.
      diff = $signed({1'b0, next_target}) - $signed({1'b0, code_q});
      if ((SLEW_MAX == 0) || ((diff <= SLEW_S) && (diff >= -SLEW_S))) begin
         code_step = next_target;
      end else if (!diff[DAC_W]) begin
         code_step = code_q + SLEW_U;
      end else begin
         code_step = code_q - SLEW_U;
      end

      if (tick) begin
         code_d = code_step;
      end

      if (grant_vld) begin
         target_d = next_target;
         last_d   = winner;
         gid_d    = winner;
         if (winner == REQ_TEST) begin
            ready_d[1] = 1'b1;
         end else begin
            ready_d[0] = 1'b1;
         end
      end

      if (req0_valid && ready_q[0]) begin
         ready_d[0] = 1'b0;
         data0_d    = req0_data;
      end
      if (req1_valid && ready_q[1]) begin
         ready_d[1] = 1'b0;
         data1_d    = req1_data;
      end

      if (underrun_clr) begin
         und_d = 1'b0;
      end
      if (eligible && (full == 2'b00)) begin
         und_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         ready_q  <= 2'b11;
         data0_q  <= '0;
         data1_q  <= '0;
         code_q   <= RST_CODE;
         target_q <= RST_CODE;
         last_q   <= REQ_TEST;
         gid_q    <= REQ_CORE;
         upd_q    <= 1'b0;
         und_q    <= 1'b0;
      end else begin
         ready_q  <= ready_d;
         data0_q  <= data0_d;
         data1_q  <= data1_d;
         code_q   <= code_d;
         target_q <= target_d;
         last_q   <= last_d;
         gid_q    <= gid_d;
         upd_q    <= upd_d;
         und_q    <= und_d;
      end
   end

   assign req0_ready = ready_q[0];
   assign req1_ready = ready_q[1];
   assign dac_code   = code_q;
   assign dac_update = upd_q;
   assign grant_id   = gid_q;
   assign underrun   = und_q;

endmodule : dac_update_arbiter
